neuron_scheduler: RTL
=====================

# neuron_scheduler

Time-multiplexing controller for the neuron pool. It generates the slow `neuron_clk` from `rawclk` through a programmable half-period divider and sweeps `neuronCounter` through 4 phases per neuron, for 2^(NN+1) neurons. It starts and stops the pool only on frame boundaries, and captures motoneuron spikes into a small spike-ID FIFO that the host drains. It sits between the host register interface and `neuron_pool`, and drives that block's `half_cnt`-derived clock and its `neuronCounter` input.

## Interface
Parameters:
- `NN`, 8: neuron count is 2^(NN+1); counter width is NN+3.
- `FIFO_DEPTH`, 16: spike FIFO entries, a power of 2.

Ports:
- `rawclk` in 1: single system clock.
- `reset_sim_n` in 1: reset, asynchronous, active-low.
- `half_cnt` in 32: divider half-period minus one, in `rawclk` cycles.
- `enable` in 1: level; request run (1) or stop at end of frame (0).
- `spike_in` in 1: `MN_spike` from the pool.
- `spk_rd_en` in 1: pop the FIFO head.
- `ovf_clr` in 1: clear the sticky overflow flag.
- `neuron_clk` out 1: divided clock.
- `neuronCounter` out NN+3: bits [1:0] are the phase, bits [NN+2:2] are the neuron index.
- `tick` out 1: one-cycle strobe on each counter advance.
- `frame_done` out 1: one-cycle strobe when the counter wraps.
- `busy` out 1: high when not IDLE.
- `spk_dout` out 16: FIFO head (first-word-fall-through).
- `spk_empty` out 1: FIFO empty.
- `spk_overflow` out 1: sticky flag; a push was dropped.

## Operation
- States:
  - IDLE → RUN on `enable`=1.
  - RUN → STOPPING on `enable`=0.
  - STOPPING → RUN on `enable`=1.
  - STOPPING → IDLE on the wrap tick.
  - RUN stays RUN across wraps.
- IDLE behaviour: `neuron_clk`=0, divider count=0, `neuronCounter` held at 0.
- Divider, in RUN and STOPPING:
  - If `delay_cnt` < `half_cnt`: increment `delay_cnt`.
  - Otherwise: toggle `neuron_clk` and set `delay_cnt`=0.
  - `half_cnt` is compared live. A decrease below the current count causes a toggle on the next cycle.
- Advance:
  - On a toggle 1→0, `tick`=1 and `neuronCounter` increments modulo 2^(NN+3).
  - The counter is therefore stable across every rising edge of `neuron_clk`.
- Wrap: the increment from all-ones to 0 also asserts `frame_done` in the same cycle. A frame-count register increments on that cycle.
- Spike capture:
  - Push condition: `tick`=1 and the pre-increment phase is 2'b11 and `spike_in`=1.
  - Pushed word: bit 15 = frame-count LSB, bits [NN:0] = pre-increment index, all other bits 0.
- FIFO rules:
  - Push while full: data dropped, `spk_overflow` set.
  - Push and pop in the same cycle while full: both take effect, no overflow.
  - Pop while empty: ignored.
  - `spk_dout` is valid whenever `spk_empty`=0.
  - `ovf_clr` takes priority over a same-cycle overflow set.
- `enable` drop mid-frame: the frame completes and `frame_done` fires, then the block enters IDLE with the counter at 0. The FIFO is never cleared by stop or start.
- Reset values (asynchronous, all registers):
  - state IDLE, `neuron_clk` 0, `neuronCounter` 0, `tick` 0, `frame_done` 0, `busy` 0.
  - FIFO empty, so `spk_empty`=1 and `spk_dout`=0.
  - `spk_overflow` 0, frame count 0.
- Reset asserted mid-frame discards all state, including FIFO contents.

## Timing
- All outputs are registered on `rawclk`.
- `neuron_clk` period is 2·(`half_cnt`+1) cycles. `half_cnt`=0 gives period 2.
- First toggle after IDLE→RUN occurs `half_cnt`+1 cycles after the state change. It is a 0→1 toggle, so there is no tick.
- Tick spacing is 2·(`half_cnt`+1) cycles.
- Frame length is 2^(NN+3) ticks.
- `busy` rises one cycle after `enable` is sampled high in IDLE.
- `busy` falls in the cycle after the wrap tick when in STOPPING.
- A FIFO push is visible on `spk_dout` and `spk_empty` one cycle after the tick.
- A pop advances `spk_dout` on the next cycle.

## Structure
- Shared package `neuron_pkg`: state enumeration (IDLE, RUN, STOPPING) and the `spkid` field positions (bit 15 frame parity, index LSB at 0).
- Sub-module `spk_fifo`: synchronous, parameterised FWFT FIFO with push, pop, full, empty, and the overflow flag.
- Divider, FSM and counter stay in the top module.

## Test plan
1. Reset: hold `reset_sim_n`=0 mid-run → all outputs at reset values within the same cycle; after release, IDLE with `spk_empty`=1.
2. Divider with NN=1, `half_cnt`=2, `enable`=1:
   - `neuron_clk` period is 6 cycles.
   - `tick` every 6 cycles.
   - `frame_done` after 16 ticks, 96 cycles apart.
3. Stop mid-frame: drop `enable` at counter 5 → counting continues to 15, then `frame_done`, `busy`=0, counter 0. Re-raising `enable` at counter 10 instead keeps RUN with no stop.
4. Spike capture, NN=1:
   - `spike_in`=1 only on the tick at counter 7 (index 1, phase 3) → `spk_dout`=16'h0001 one cycle later.
   - Same event in the next frame → 16'h8001.
   - Spike at phase 1 → no push.
5. Overflow, `FIFO_DEPTH`=4:
   - 5 pushes without pops → 4 entries kept, `spk_overflow`=1.
   - Push and pop in the same cycle while full → no overflow.
   - `ovf_clr` → 0.
6. Live `half_cnt` change from 10 to 1 while `delay_cnt`=7 → toggle on the next cycle, then period 4.

Source files
------------

// File: rtl/neuron_scheduler_pkg.sv
// Shared types for the neuron scheduler: FSM states and spike-ID word layout.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } sched_state_t;

  localparam int SPKID_W          = 16;
  localparam int SPKID_PARITY_BIT = 15;
  localparam int SPKID_INDEX_LSB  = 0;
  localparam int SPKID_INDEX_W    = 15;

  // Index is passed zero-extended; the parity bit overrides whatever sits at its position.
  function automatic logic [SPKID_W-1:0] make_spkid(input logic parity,
                                                    input logic [SPKID_INDEX_W-1:0] index);
    logic [SPKID_W-1:0] word;
    word = SPKID_W'(index) << SPKID_INDEX_LSB;
    word[SPKID_PARITY_BIT] = parity;
    return word;
  endfunction

endpackage

// File: rtl/neuron_scheduler_if.sv
// Host register-side bundle of the scheduler: divider/run control and the spike FIFO read port.
interface neuron_scheduler_if;
  import neuron_pkg::*;

  logic [31:0]        half_cnt;
  logic               enable;
  logic               spk_rd_en;
  logic               ovf_clr;
  logic               busy;
  logic [SPKID_W-1:0] spk_dout;
  logic               spk_empty;
  logic               spk_overflow;

  modport master (
    output half_cnt, enable, spk_rd_en, ovf_clr,
    input  busy, spk_dout, spk_empty, spk_overflow
  );

  modport slave (
    input  half_cnt, enable, spk_rd_en, ovf_clr,
    output busy, spk_dout, spk_empty, spk_overflow
  );

endinterface

// File: rtl/neuron_scheduler_spk_fifo.sv
// First-word-fall-through spike-ID FIFO with a sticky overflow flag.
module spk_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_clr)                      overflow <= 1'b0;
      else if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Time-multiplexing controller: divides rawclk into neuron_clk, sweeps neuronCounter
// frame by frame and queues motoneuron spike IDs for the host.
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int NN         = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               rawclk,
  input  logic               reset_sim_n,
  neuron_scheduler_if.slave  host,
  input  logic               spike_in,
  output logic               neuron_clk,
  output logic [NN+2:0]      neuronCounter,
  output logic               tick,
  output logic               frame_done
);

  localparam int CW = NN + 3;

  sched_state_t       state;
  sched_state_t       state_next;
  logic [31:0]        delay_cnt;
  logic               frame_cnt;
  logic               running;
  logic               toggle;
  logic               advance;
  logic               push;
  logic [CW-1:0]      prev_count;
  logic [SPKID_W-1:0] spk_word;

  assign running = (state != IDLE);
  assign toggle  = running && (delay_cnt >= host.half_cnt);
  assign advance = toggle && neuron_clk;

  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n) state <= IDLE;
    else              state <= state_next;
  end

  // Stopping only leaves for IDLE once the wrap strobe is out, so a frame is never cut short.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (host.enable) state_next = RUN;
      RUN:      if (!host.enable) state_next = STOPPING;
      STOPPING: begin
        if (host.enable)     state_next = RUN;
        else if (frame_done) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    host.busy = (state != IDLE);
  end

  // Counter only moves on the falling toggle, keeping it stable around each neuron_clk rise.
  always_ff @(posedge rawclk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      delay_cnt     <= '0;
      neuron_clk    <= 1'b0;
      neuronCounter <= '0;
      tick          <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= 1'b0;
    end else begin
      tick       <= advance;
      frame_done <= advance && (&neuronCounter);
      if (advance && (&neuronCounter)) frame_cnt <= ~frame_cnt;
      if (!running) begin
        delay_cnt     <= '0;
        neuron_clk    <= 1'b0;
        neuronCounter <= '0;
      end else if (toggle) begin
        delay_cnt  <= '0;
        neuron_clk <= ~neuron_clk;
        if (neuron_clk) neuronCounter <= neuronCounter + 1'b1;
      end else begin
        delay_cnt <= delay_cnt + 32'd1;
      end
    end
  end

  // During the tick cycle the counter already shows the new value; step back one for the
  // neuron that just finished, and undo the parity flip when that step crossed the wrap.
  assign prev_count = neuronCounter - CW'(1);
  assign push       = tick && (prev_count[1:0] == 2'b11) && spike_in;
  assign spk_word   = make_spkid(frame_cnt ^ frame_done,
                                 SPKID_INDEX_W'(prev_count[CW-1:2]));

  spk_fifo #(
    .WIDTH (SPKID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_spk_fifo (
    .clk      (rawclk),
    .rst_n    (reset_sim_n),
    .push     (push),
    .din      (spk_word),
    .pop      (host.spk_rd_en),
    .ovf_clr  (host.ovf_clr),
    .dout     (host.spk_dout),
    .empty    (host.spk_empty),
    .overflow (host.spk_overflow)
  );

endmodule
